// File: rtl/sdi_chunk_streamer_pkg.sv
// rtl/sdi_chunk_streamer_pkg.sv - shared state encoding and SDI chunk constant
package sdi_chunk_streamer_pkg;

  // Decoder guaranteed-space size when DREQ is high on the SDI path.
  localparam int SDI_CHUNK = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_ON,
    ST_LOAD,
    ST_GO,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CS_OFF,
    ST_GAP
  } state_t;

endpackage

// File: rtl/sdi_chunk_streamer_byte_fifo.sv
// rtl/sdi_chunk_streamer_byte_fifo.sv - byte FIFO with occupancy count
//   clk, rst     : clock, asynchronous active-high reset
//   wr_data_i    : byte to store
//   wr_valid_i   : write request
//   wr_ready_o   : not full; write accepted when wr_valid_i and wr_ready_o
//   rd_en_i      : pop the head (ignored when empty)
//   rd_data_o    : current head byte
//   count_o      : bytes buffered
module sdi_chunk_streamer_byte_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign wr_ready_o = (count_q != CW'(DEPTH));
  assign wr_en      = wr_valid_i & wr_ready_o;
  assign rd_en      = rd_en_i & (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdi_chunk_streamer.sv
// rtl/sdi_chunk_streamer.sv - buffers audio bytes and feeds the SDI SPI master in DREQ-gated chunks
//   clk, rst     : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready : byte stream from the file reader
//   flush        : allow a partial chunk while high
//   dreq         : decoder DREQ (asynchronous)
//   spi_tx_data/spi_go/spi_busy : byte handshake with the SPI master
//   xdcs         : decoder data chip-select, active-low
//   fifo_count   : bytes buffered
//   chunk_done   : one-cycle pulse when a chunk finishes
module sdi_chunk_streamer
  import sdi_chunk_streamer_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int CHUNK  = SDI_CHUNK,
  parameter int CS_GAP = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic          dreq,
  output logic [7:0]    spi_tx_data,
  output logic          spi_go,
  input  logic          spi_busy,
  output logic          xdcs,
  output logic [CW-1:0] fifo_count,
  output logic          chunk_done
);

  localparam int BW = $clog2(CHUNK) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_len_q, burst_len_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          xdcs_q, xdcs_d;
  logic          dreq_meta_q, dreq_s_q;
  logic          pop;
  logic          go;
  logic          done;
  logic [7:0]    fifo_head;
  logic          have_chunk;

  sdi_chunk_streamer_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (in_data),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_head),
    .count_o    (fifo_count)
  );

  // DREQ comes from the decoder clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dreq_meta_q <= 1'b0;
      dreq_s_q    <= 1'b0;
    end else begin
      dreq_meta_q <= dreq;
      dreq_s_q    <= dreq_meta_q;
    end
  end

  assign have_chunk = fifo_count >= CW'(CHUNK);

  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    byte_cnt_d  = byte_cnt_q;
    gap_d       = gap_q;
    tx_data_d   = tx_data_q;
    xdcs_d      = xdcs_q;
    pop         = 1'b0;
    go          = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dreq_s_q && (have_chunk || (flush && fifo_count != '0))) begin
          // Length is frozen here so later writes or flush changes cannot resize the chunk.
          burst_len_d = have_chunk ? BW'(CHUNK) : BW'(fifo_count);
          state_d     = ST_CS_ON;
        end
      end
      ST_CS_ON: begin
        xdcs_d     = 1'b0;
        byte_cnt_d = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        pop       = 1'b1;
        tx_data_d = fifo_head;
        state_d   = ST_GO;
      end
      ST_GO: begin
        go      = 1'b1;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        // Busy rises one cycle after go is sampled; wait for it before looking for the fall.
        if (spi_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!spi_busy) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == burst_len_q - BW'(1)) state_d = ST_CS_OFF;
          else                                    state_d = ST_LOAD;
        end
      end
      ST_CS_OFF: begin
        xdcs_d  = 1'b1;
        done    = 1'b1;
        gap_d   = GW'(CS_GAP - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_len_q <= '0;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      tx_data_q   <= 8'h00;
      xdcs_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_q       <= gap_d;
      tx_data_q   <= tx_data_d;
      xdcs_q      <= xdcs_d;
    end
  end

  assign spi_tx_data = tx_data_q;
  assign spi_go      = go;
  assign xdcs        = xdcs_q;
  assign chunk_done  = done;

endmodule

// File: tb/tb_sdi_chunk_streamer.sv
// tb/tb_sdi_chunk_streamer.sv - directed self-checking bench for sdi_chunk_streamer
module tb_sdi_chunk_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       dreq = 1'b0;
  logic [7:0] spi_tx_data;
  logic       spi_go;
  logic       spi_busy = 1'b0;
  logic       xdcs;
  logic [6:0] fifo_count;
  logic       chunk_done;

  int checks = 0;
  int failures = 0;
  int go_cnt = 0;
  int cd_cnt = 0;
  int busy_cnt = 0;
  int go_busy_viol = 0;
  int go_cs_viol = 0;
  logic [7:0] cap[$];

  sdi_chunk_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .dreq        (dreq),
    .spi_tx_data (spi_tx_data),
    .spi_go      (spi_go),
    .spi_busy    (spi_busy),
    .xdcs        (xdcs),
    .fifo_count  (fifo_count),
    .chunk_done  (chunk_done)
  );

  always #5 clk = ~clk;

  // SPI master model: samples go, raises busy next cycle, holds it 8 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_busy <= 1'b0;
      busy_cnt <= 0;
    end else if (spi_go) begin
      cap.push_back(spi_tx_data);
      go_cnt <= go_cnt + 1;
      if (spi_busy) go_busy_viol <= go_busy_viol + 1;
      if (xdcs !== 1'b0) go_cs_viol <= go_cs_viol + 1;
      spi_busy <= 1'b1;
      busy_cnt <= 8;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) spi_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && chunk_done === 1'b1) cd_cnt <= cd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_chunks(input string tag, input int n);
    int start;
    int k;
    start = cd_cnt;
    k = 0;
    while (cd_cnt < start + n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, cd_cnt - start, n);
    idle(6);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [7:0] first);
    logic [7:0] e;
    check({tag, "_count"}, cap.size(), n);
    for (int i = 0; i < n && i < cap.size(); i++) begin
      e = first + 8'(i);
      check({tag, "_byte"}, cap[i], e);
    end
    cap.delete();
  endtask

  initial begin
    int start;
    int k;
    logic acc;
    logic [7:0] nd;

    // Reset state
    idle(2);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_xdcs", xdcs, 1);
    check("rst_spi_go", spi_go, 0);
    check("rst_tx_data", spi_tx_data, 8'h00);
    check("rst_chunk_done", chunk_done, 0);
    rst = 1'b0;

    // Full chunk with DREQ already high
    dreq = 1'b1;
    for (int i = 0; i < 32; i++) push(8'(i));
    wait_chunks("full_chunk_done", 1);
    check_bytes("full_chunk", 32, 8'h00);
    check("full_cd_once", cd_cnt, 1);
    check("full_fifo_empty", fifo_count, 0);
    check("full_xdcs_high", xdcs, 1);

    // Asynchronous reset mid-cycle with data buffered
    dreq = 1'b0;
    idle(3);
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    check("pre_rst_count", fifo_count, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_fifo_count", fifo_count, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_xdcs", xdcs, 1);
    check("arst_spi_go", spi_go, 0);
    check("arst_tx_data", spi_tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // DREQ gating
    for (int i = 0; i < 40; i++) push(8'h40 + 8'(i));
    idle(20);
    check("gate_no_go", cap.size(), 0);
    check("gate_xdcs", xdcs, 1);
    check("gate_count", fifo_count, 40);
    dreq = 1'b1;
    wait_chunks("gate_chunk_done", 1);
    idle(40);
    check_bytes("gate_chunk", 32, 8'h40);
    check("gate_left", fifo_count, 8);
    check("gate_xdcs_idle", xdcs, 1);

    // Flush drains the partial remainder
    flush = 1'b1;
    wait_chunks("flush8_done", 1);
    check_bytes("flush8", 8, 8'h60);
    check("flush8_empty", fifo_count, 0);
    flush = 1'b0;

    // Five bytes without flush stay put, then flush sends them
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    idle(30);
    check("noflush_no_go", cap.size(), 0);
    check("noflush_count", fifo_count, 5);
    flush = 1'b1;
    wait_chunks("flush5_done", 1);
    check_bytes("flush5", 5, 8'hA0);
    check("flush5_xdcs", xdcs, 1);
    check("flush5_empty", fifo_count, 0);
    flush = 1'b0;

    // Full FIFO
    dreq = 1'b0;
    idle(4);
    for (int i = 0; i < 64; i++) push(8'h80 + 8'(i));
    check("full_in_ready", in_ready, 0);
    check("full_count", fifo_count, 64);
    push(8'hEE);
    check("full_65th_ignored", fifo_count, 64);
    start = cd_cnt;
    nd = 8'hC0;
    @(negedge clk);
    in_data  = nd;
    in_valid = 1'b1;
    dreq     = 1'b1;
    k = 0;
    while (cd_cnt == start && k < 3000) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nd = nd + 8'h01;
        in_data = nd;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("refill_chunk_done", cd_cnt - start, 1);
    check("refill_count", fifo_count, 64);
    check("refill_in_ready", in_ready, 0);
    check("refill_accepted", nd, 8'hE0);
    check_bytes("refill_chunk", 32, 8'h80);
    wait_chunks("refill_drain_done", 2);
    check_bytes("refill_drain", 64, 8'hA0);
    check("refill_drain_empty", fifo_count, 0);

    // Reset in the middle of a chunk
    dreq = 1'b0;
    idle(4);
    for (int i = 0; i < 32; i++) push(8'h10 + 8'(i));
    dreq = 1'b1;
    k = 0;
    while (cap.size() < 11 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_bytes("midrst_partial", 11, 8'h10);
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_xdcs", xdcs, 1);
    check("midrst_fifo_empty", fifo_count, 0);
    @(negedge clk);
    rst = 1'b0;
    cap.delete();
    for (int i = 0; i < 32; i++) push(8'h70 + 8'(i));
    wait_chunks("midrst_fresh_done", 1);
    check_bytes("midrst_fresh", 32, 8'h70);
    check("midrst_fresh_empty", fifo_count, 0);

    check("go_while_busy", go_busy_viol, 0);
    check("go_with_xdcs_high", go_cs_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
